conv33_stream_ctrl: RTL and testbench
=====================================

// Module: conv33_stream_ctrl
// PURPOSE
//  Sequencer for the 3x3 naive-compute stencil pipeline: input register ->
//  line buffer -> 9-tap adder.
//  Raster-scans one IMG_W x IMG_H frame per start pulse. Drives input-read
//  valid, the line-buffer clock enable and the output write enable. Stalls the
//  whole pipeline when upstream is empty or downstream is not ready.
//  Asserts write enable only for fully populated windows, i.e. the window's
//  bottom-right pixel has x>=2 and y>=2.
// PARAMETERS
//  IMG_W  64  frame width in pixels (>=3)
//  IMG_H  64  frame height in pixels (>=3)
//  LAT    1   advances from input accept until that pixel's window is at the adder output (>=1)
// PORTS
//  clk                       in   1   clock, rising edge
//  reset                     in   1   synchronous, active-high
//  start                     in   1   begin a frame; sampled in IDLE only
//  in_avail                  in   1   upstream holds a pixel
//  out_ready                 in   1   downstream can take a result this cycle
//  in_inst_input_read_valid  out  1   pixel consumed this cycle
//  ub_clk_en                 out  1   advance input reg + line buffer this cycle
//  out_inst_output_write_en  out  1   adder output is a valid window this cycle
//  busy                      out  1   state is RUN or DRAIN
//  done                      out  1   one-cycle pulse at frame end
//  out_count                 out  clog2((IMG_W-2)*(IMG_H-2)+1)  results written this frame
// BEHAVIOUR
//  States:
//   - IDLE -> RUN on start.
//   - RUN -> DRAIN on the advance that accepts pixel (IMG_W-1, IMG_H-1).
//   - DRAIN -> DONE after LAT further advances.
//   - DONE -> IDLE unconditionally.
//  Advance:
//   - RUN: adv = in_avail & out_ready.
//   - DRAIN: adv = out_ready.
//   - IDLE/DONE: adv = 0.
//   - ub_clk_en = adv; no state changes without adv.
//  Reads: in_inst_input_read_valid = adv & (state==RUN).
//  Scan counters x, y:
//   - Both 0 on entering RUN; they hold the coordinates of the next pixel to accept.
//   - On each RUN adv, x increments; at x==IMG_W-1, x wraps to 0 and y increments.
//   - At the last pixel they do not wrap into a new frame.
//  Window flags:
//   - Shift register vp[LAT-1:0] shifts on every adv.
//   - Shift-in value is (x>=2 & y>=2) during RUN and 0 during DRAIN.
//  Write enable:
//   - out_inst_output_write_en = adv & vp[LAT-1], combinational, same cycle as adv.
//   - Never asserted while out_ready=0.
//  out_count:
//   - Cleared on entering RUN; increments on each write enable.
//   - Saturates at (IMG_W-2)*(IMG_H-2).
//   - Holds its value through DONE and IDLE.
//  done: high exactly the one cycle in DONE. busy: high in RUN and DRAIN.
//  start: ignored unless in IDLE. A start during DONE is dropped.
//  Stall: in_avail=0 or out_ready=0 freezes x, y, vp and the state. No pixel is
//   lost or duplicated.
//  Reset (any state, including mid-frame):
//   - Next state IDLE; x=y=0; vp=0; out_count=0.
//   - All outputs deasserted the cycle after reset is sampled.
//   - Line buffer contents are don't-care; the next frame refills them.
//  Expected totals per frame:
//   - IMG_W*IMG_H read strobes.
//   - (IMG_W-2)*(IMG_H-2) write enables.
//   - IMG_W*IMG_H+LAT advances.
// TESTING
//  1 W=4,H=4,LAT=1, start, in_avail=out_ready=1 ->
//    - 16 reads in consecutive cycles.
//    - write_en on adv #12,13,16,17 (1-based), the 17th adv being the DRAIN adv.
//    - done 1 cycle later; out_count=4.
//  2 Same frame, in_avail low every other cycle ->
//    - Identical write_en sequence in adv numbering.
//    - No reads or advances during the gaps.
//  3 out_ready=0 for 5 cycles at the RUN->DRAIN boundary ->
//    - Reads, ub_clk_en and write_en all held low; state held.
//    - Completion resumes after release; out_count=4.
//  4 reset asserted at adv #9 ->
//    - IDLE next cycle; all outputs 0; out_count=0.
//    - A fresh start yields a full correct 4x4 frame.
//  5 start held high continuously and pulsed during RUN ->
//    - No restart mid-frame.
//    - After done, the next frame begins from IDLE with counters cleared.
//  6 W=64,H=64,LAT=3 random in_avail/out_ready ->
//    - 4096 reads, 3844 writes, exactly one done pulse.
//    - Write pattern matches the reference model.

Source files
------------

// File: rtl/conv33_stream_ctrl_if.sv
// Stream-side signals of the 3x3 stencil sequencer: frame start, upstream/downstream
// handshakes, pipeline strobes and frame status.
interface conv33_stream_ctrl_if #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
);
    localparam int CNT_W = $clog2((IMG_W - 2) * (IMG_H - 2) + 1);

    logic             start;
    logic             in_avail;
    logic             out_ready;
    logic             in_inst_input_read_valid;
    logic             ub_clk_en;
    logic             out_inst_output_write_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] out_count;

    modport master (
        output start, in_avail, out_ready,
        input  in_inst_input_read_valid, ub_clk_en, out_inst_output_write_en,
               busy, done, out_count
    );

    modport slave (
        input  start, in_avail, out_ready,
        output in_inst_input_read_valid, ub_clk_en, out_inst_output_write_en,
               busy, done, out_count
    );
endinterface

// File: rtl/conv33_stream_ctrl.sv
// Raster-scan sequencer for the input reg -> line buffer -> 9-tap adder pipeline.
// One frame per start; the whole pipeline advances only when both ends allow it.
module conv33_stream_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    conv33_stream_ctrl_if.slave  bus
);
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int DW     = $clog2(LAT + 1);
    localparam int CNT_W  = $clog2((IMG_W - 2) * (IMG_H - 2) + 1);
    localparam int WR_MAX = (IMG_W - 2) * (IMG_H - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [XW-1:0]    x_reg;
    logic [YW-1:0]    y_reg;
    logic [LAT-1:0]   vp_reg;
    logic [LAT-1:0]   vp_next;
    logic [DW-1:0]    drain_reg;
    logic [CNT_W-1:0] count_reg;
    logic             busy_reg;
    logic             done_reg;

    logic adv;
    logic window_full;
    logic last_pix;
    logic last_drain;
    logic wr_en;

    always_comb begin
        adv = 1'b0;
        case (state_reg)
            RUN:     adv = bus.in_avail & bus.out_ready;
            DRAIN:   adv = bus.out_ready;
            default: adv = 1'b0;
        endcase
    end

    assign window_full = (x_reg >= XW'(2)) && (y_reg >= YW'(2));
    assign last_pix    = (x_reg == XW'(IMG_W - 1)) && (y_reg == YW'(IMG_H - 1));
    assign last_drain  = (drain_reg == DW'(LAT - 1));
    assign wr_en       = adv & vp_reg[LAT-1];

    // Window-valid flags travel alongside the pixel data; drain pushes bubbles.
    assign vp_next[0] = (state_reg == RUN) & window_full;
    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_vp
            assign vp_next[gi] = vp_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            vp_reg    <= '0;
            drain_reg <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            if (wr_en && (count_reg != CNT_W'(WR_MAX)))
                count_reg <= count_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= RUN;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        vp_reg    <= '0;
                        drain_reg <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (adv) begin
                        vp_reg <= vp_next;
                        // Coordinates stay parked on the last pixel rather than wrapping.
                        if (last_pix) begin
                            state_reg <= DRAIN;
                            drain_reg <= '0;
                        end else if (x_reg == XW'(IMG_W - 1)) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 1'b1;
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (adv) begin
                        vp_reg <= vp_next;
                        if (last_drain) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            drain_reg <= drain_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_inst_input_read_valid = adv & (state_reg == RUN);
    assign bus.ub_clk_en                = adv;
    assign bus.out_inst_output_write_en = wr_en;
    assign bus.busy                     = busy_reg;
    assign bus.done                     = done_reg;
    assign bus.out_count                = count_reg;
endmodule

// File: tb/tb_conv33_stream_ctrl.sv
// Bench for conv33_stream_ctrl: a 4x4/LAT=1 instance for directed frames and a
// 64x64/LAT=3 instance under random handshakes, both against a frame-level model.
module tb_conv33_stream_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv33_stream_ctrl_if #(.IMG_W(4),  .IMG_H(4))  ifs ();
    conv33_stream_ctrl_if #(.IMG_W(64), .IMG_H(64)) ifl ();

    conv33_stream_ctrl #(.IMG_W(4), .IMG_H(4), .LAT(1)) dut_s (
        .clk(clk), .reset(reset), .bus(ifs)
    );
    conv33_stream_ctrl #(.IMG_W(64), .IMG_H(64), .LAT(3)) dut_l (
        .clk(clk), .reset(reset), .bus(ifl)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Model state: frame active, done cycle pending, advances so far, writes so far.
    bit s_act = 0, s_donef = 0;
    int s_n = 0, s_cnt = 0;
    bit l_act = 0, l_donef = 0;
    int l_n = 0, l_cnt = 0;

    int s_rd_tot = 0, s_done_tot = 0;
    int s_we_q[$];
    int l_rd_tot = 0, l_we_tot = 0, l_done_tot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit pix_ok(input int p, input int w, input int h);
        return (p >= 0) && (p < w * h) && ((p % w) >= 2) && ((p / w) >= 2);
    endfunction

    function automatic bit adv_f(input bit act, input int n, input int wh, input bit av, input bit rd);
        if (!act) return 1'b0;
        return (n < wh) ? (av && rd) : rd;
    endfunction

    // Advance k (1-based) delivers the window of pixel k-1-lat to the adder output.
    function automatic bit we_f(input int n, input int w, input int h, input int lat);
        return pix_ok(n - lat, w, h);
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit av, input bit rd,
                              input int w, input int h, input int lat,
                              inout bit act, inout bit donef, inout int n, inout int cnt);
        if (rst) begin
            act = 0; donef = 0; n = 0; cnt = 0;
        end else if (donef) begin
            donef = 0;
        end else if (!act) begin
            if (st) begin act = 1; n = 0; cnt = 0; end
        end else if (adv_f(act, n, w * h, av, rd)) begin
            if (we_f(n, w, h, lat)) cnt++;
            n++;
            if (n == w * h + lat) begin act = 0; donef = 1; end
        end
    endtask

    always @(posedge clk) begin : s_mdl
        bit a, d;
        int n, c;
        a = s_act; d = s_donef; n = s_n; c = s_cnt;
        model_step(reset, ifs.start, ifs.in_avail, ifs.out_ready, 4, 4, 1, a, d, n, c);
        s_act <= a; s_donef <= d; s_n <= n; s_cnt <= c;
    end

    always @(posedge clk) begin : l_mdl
        bit a, d;
        int n, c;
        a = l_act; d = l_donef; n = l_n; c = l_cnt;
        model_step(reset, ifl.start, ifl.in_avail, ifl.out_ready, 64, 64, 3, a, d, n, c);
        l_act <= a; l_donef <= d; l_n <= n; l_cnt <= c;
    end

    always @(negedge clk) begin : s_mon
        bit ea;
        if (mon_en) begin
            ea = adv_f(s_act, s_n, 16, ifs.in_avail, ifs.out_ready);
            chk("s_rd",   ifs.in_inst_input_read_valid, ea && (s_n < 16));
            chk("s_ub",   ifs.ub_clk_en, ea);
            chk("s_we",   ifs.out_inst_output_write_en, ea && we_f(s_n, 4, 4, 1));
            chk("s_busy", ifs.busy, s_act);
            chk("s_done", ifs.done, s_donef);
            chk("s_cnt",  ifs.out_count, s_cnt);
            if (ifs.in_inst_input_read_valid === 1'b1) s_rd_tot++;
            if (ifs.out_inst_output_write_en === 1'b1) s_we_q.push_back(s_n + 1);
            if (ifs.done === 1'b1) s_done_tot++;
        end
    end

    always @(negedge clk) begin : l_mon
        bit ea;
        if (mon_en) begin
            ea = adv_f(l_act, l_n, 4096, ifl.in_avail, ifl.out_ready);
            chk("l_rd",   ifl.in_inst_input_read_valid, ea && (l_n < 4096));
            chk("l_ub",   ifl.ub_clk_en, ea);
            chk("l_we",   ifl.out_inst_output_write_en, ea && we_f(l_n, 64, 64, 3));
            chk("l_busy", ifl.busy, l_act);
            chk("l_done", ifl.done, l_donef);
            chk("l_cnt",  ifl.out_count, l_cnt);
            if (ifl.in_inst_input_read_valid === 1'b1) l_rd_tot++;
            if (ifl.out_inst_output_write_en === 1'b1) l_we_tot++;
            if (ifl.done === 1'b1) l_done_tot++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_small_frame(input string tag);
        int exp_q[4] = '{12, 13, 16, 17};
        chk($sformatf("%s_reads", tag), s_rd_tot, 16);
        chk($sformatf("%s_wecnt", tag), s_we_q.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_we%0d", tag, k), (k < s_we_q.size()) ? s_we_q[k] : -1, exp_q[k]);
        chk($sformatf("%s_outcnt", tag), ifs.out_count, 4);
        $display("frame %s: reads=%0d writes=%0d out_count=%0d", tag, s_rd_tot, s_we_q.size(), ifs.out_count);
    endtask

    // mode 0: free-running, 1: in_avail every other cycle, 2: out_ready held low 5 cycles after pixel 16
    task automatic run_small(input string tag, input int mode);
        int d0;
        int hold;
        d0 = s_done_tot;
        hold = 0;
        s_rd_tot = 0;
        s_we_q.delete();
        ifs.in_avail = 1'b0;
        ifs.out_ready = 1'b1;
        ifs.start = 1'b1;
        tick();
        ifs.start = 1'b0;
        for (int i = 0; i < 400 && s_done_tot == d0; i++) begin
            ifs.in_avail = (mode == 1) ? i[0] : 1'b1;
            if (mode == 2 && s_n == 16 && hold < 5) begin
                ifs.out_ready = 1'b0;
                hold++;
            end else begin
                ifs.out_ready = 1'b1;
            end
            tick();
        end
        chk($sformatf("%s_done", tag), s_done_tot - d0, 1);
        chk_small_frame(tag);
    endtask

    task automatic chk_quiet(input string tag);
        chk($sformatf("%s_rd", tag),   ifs.in_inst_input_read_valid, 0);
        chk($sformatf("%s_ub", tag),   ifs.ub_clk_en, 0);
        chk($sformatf("%s_we", tag),   ifs.out_inst_output_write_en, 0);
        chk($sformatf("%s_busy", tag), ifs.busy, 0);
        chk($sformatf("%s_done", tag), ifs.done, 0);
        chk($sformatf("%s_cnt", tag),  ifs.out_count, 0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        ifs.start = 1'b0; ifs.in_avail = 1'b0; ifs.out_ready = 1'b0;
        ifl.start = 1'b0; ifl.in_avail = 1'b0; ifl.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        chk_quiet("reset");
        chk("reset_l_busy", ifl.busy, 0);
        chk("reset_l_cnt",  ifl.out_count, 0);

        run_small("t1", 0);
        run_small("t2", 1);
        run_small("t3", 2);

        // Reset in the cycle of advance #9.
        ifs.in_avail = 1'b1; ifs.out_ready = 1'b1;
        ifs.start = 1'b1;
        tick();
        ifs.start = 1'b0;
        for (int i = 0; i < 50 && s_n != 8; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("t4_after_reset");
        run_small("t4", 0);

        // start held continuously: back-to-back frames, no mid-frame restart.
        d0 = s_done_tot;
        ifs.start = 1'b1; ifs.in_avail = 1'b1; ifs.out_ready = 1'b1;
        for (int i = 0; i < 200 && s_done_tot == d0; i++) tick();
        chk("t5_first_done", s_done_tot - d0, 1);
        s_rd_tot = 0;
        s_we_q.delete();
        repeat (4) tick();
        chk("t5_restart_busy", ifs.busy, 1);
        chk("t5_restart_cnt", ifs.out_count, 0);
        d0 = s_done_tot;
        for (int i = 0; i < 200 && s_done_tot == d0; i++) begin
            ifs.start = i[0];
            tick();
        end
        ifs.start = 1'b0;
        chk("t5_second_done", s_done_tot - d0, 1);
        chk_small_frame("t5");

        // Large frame under random handshakes.
        d0 = l_done_tot;
        ifl.start = 1'b1;
        tick();
        ifl.start = 1'b0;
        for (int i = 0; i < 30000 && l_done_tot == d0; i++) begin
            ifl.in_avail  = ($urandom_range(0, 3) != 0);
            ifl.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        repeat (5) begin
            ifl.in_avail  = ($urandom_range(0, 1) != 0);
            ifl.out_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        chk("t6_done_pulses", l_done_tot - d0, 1);
        chk("t6_reads", l_rd_tot, 4096);
        chk("t6_writes", l_we_tot, 3844);
        chk("t6_outcnt", ifl.out_count, 3844);
        $display("frame t6: reads=%0d writes=%0d out_count=%0d", l_rd_tot, l_we_tot, ifl.out_count);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
